// File: rtl/grf.sv
// 32 x 32-bit MIPS general register file: two combinational read ports, one clocked write port,
// writeback trace and saturating committed-write counter. Define GRF_BYPASS_EN for write-through forwarding.
module grf #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            WE,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  input  logic [4:0]      A3,
  input  logic [DW-1:0]   WD,
  input  logic [31:0]     PC,
  output logic [DW-1:0]   RD1,
  output logic [DW-1:0]   RD2,
  output logic [CNTW-1:0] wr_cnt
);

  logic [DW-1:0]   r_q [NREG];
  logic [DW-1:0]   r_d [NREG];
  logic [NREG-1:0] wsel;
  logic [CNTW-1:0] cnt_q;
  logic [CNTW-1:0] cnt_d;
  logic            we_clean;
  logic            commit;

  // An unknown WE falls through to the else branch, so X never writes.
  always_comb begin
    we_clean = 1'b0;
    if (WE) we_clean = 1'b1;
  end

  always_comb commit = we_clean && (A3 != 5'd0);

  for (genvar gi = 0; gi < NREG; gi++) begin : g_wsel
    localparam logic [4:0] IDX = 5'(gi);
    if (gi == 0) begin : g_zero
      assign wsel[gi] = 1'b0;
    end else begin : g_reg
      assign wsel[gi] = commit && (A3 == IDX);
    end
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      r_d[i] = wsel[i] ? WD : r_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) r_q[i] <= r_d[i];
    end
  end

  // Counter holds at all-ones; the write itself still commits.
  always_comb begin
    cnt_d = cnt_q;
    if (commit && (cnt_q != {CNTW{1'b1}})) cnt_d = cnt_q + CNTW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign wr_cnt = cnt_q;

  always_comb begin
    RD1 = (A1 == 5'd0) ? '0 : r_q[A1];
    RD2 = (A2 == 5'd0) ? '0 : r_q[A2];
`ifdef GRF_BYPASS_EN
    if (we_clean && !reset && (A3 != 5'd0) && (A3 == A1)) RD1 = WD;
    if (we_clean && !reset && (A3 != 5'd0) && (A3 == A2)) RD2 = WD;
`endif
  end

`ifndef SYNTHESIS
  // Trace stays line-comparable with the course reference output, including writes to $0.
  always_ff @(posedge clk) begin
    if (!reset && we_clean) $display("@%h: $%d <= %h", PC, A3, WD);
    if (!reset && $isunknown(WE)) $display("grf: warning, WE unknown at PC %h, write suppressed", PC);
  end
`endif

endmodule

// File: tb/tb_grf.sv
// Scoreboard bench for grf: stimulus pushes expected reads/counter, a negedge monitor pops and compares.
module tb_grf;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic            clk;
  logic            reset;
  logic            WE;
  logic [4:0]      A1, A2, A3;
  logic [31:0]     WD, PC;
  logic [31:0]     RD1, RD2;
  logic [CNTW-1:0] wr_cnt;

  grf #(.NREG(32), .DW(32), .CNTW(CNTW)) dut (
    .clk(clk), .reset(reset), .WE(WE), .A1(A1), .A2(A2), .A3(A3),
    .WD(WD), .PC(PC), .RD1(RD1), .RD2(RD2), .wr_cnt(wr_cnt)
  );

  typedef struct {
    logic [4:0]      a1;
    logic [4:0]      a2;
    logic [31:0]     rd1;
    logic [31:0]     rd2;
    logic [CNTW-1:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m [32];
  int          mcnt;
  int          n_cmp;
  int          n_err;
  int          n_tx;
  bit          done;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] model_read(input logic [4:0] a, input bit rst, input bit we,
                                             input logic [4:0] a3, input logic [31:0] wd);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : m[a];
`ifdef GRF_BYPASS_EN
    if (we && !rst && a3 != 5'd0 && a3 == a) v = wd;
`endif
    return v;
  endfunction

  task automatic step(input bit rst, input bit we, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [4:0] a3, input logic [31:0] wd, input logic [31:0] pc);
    exp_t e;
    reset = rst; WE = we; A1 = a1; A2 = a2; A3 = a3; WD = wd; PC = pc;
    e.a1  = a1;
    e.a2  = a2;
    e.rd1 = model_read(a1, rst, we, a3, wd);
    e.rd2 = model_read(a2, rst, we, a3, wd);
    e.cnt = CNTW'(mcnt);
    exp_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
      mcnt = 0;
    end else if (we && a3 != 5'd0) begin
      m[a3] = wd;
      if (mcnt < CMAX) mcnt++;
    end
    #1;
  endtask

  // Monitor: one popped expectation per negedge while entries are pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_tx++;
        n_cmp += 3;
        if (RD1 !== e.rd1) begin
          n_err++;
          $display("FAIL rd1 tx=%0d a1=%0d got %h want %h", n_tx, e.a1, RD1, e.rd1);
        end
        if (RD2 !== e.rd2) begin
          n_err++;
          $display("FAIL rd2 tx=%0d a2=%0d got %h want %h", n_tx, e.a2, RD2, e.rd2);
        end
        if (wr_cnt !== e.cnt) begin
          n_err++;
          $display("FAIL wr_cnt tx=%0d got %0d want %0d", n_tx, wr_cnt, e.cnt);
        end
        $display("tx %0d: a1=%0d rd1=%h a2=%0d rd2=%h cnt=%0d", n_tx, e.a1, RD1, e.a2, RD2, wr_cnt);
      end
    end
  end

  initial begin
    #200000;
    if (!done) begin
      $display("FAIL timeout: bench did not complete, got running want finished");
      $fatal(1, "timeout");
    end
  end

  initial begin
    n_cmp = 0; n_err = 0; n_tx = 0; mcnt = 0; done = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    reset = 1'b1; WE = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD = '0; PC = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset then sweep every address on both ports.
    step(1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) step(0, 0, 5'(i), 5'(31 - i), 0, 0, 0);

    // Basic write, then read back.
    step(0, 1, 0, 0, 5, 32'h1234_5678, 32'h0000_3000);
    step(0, 0, 5, 0, 0, 0, 32'h0000_3004);

    // Writes to $0 are discarded and not counted.
    step(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 32'h0000_3008);
    step(0, 0, 0, 0, 0, 0, 32'h0000_300C);

    // Read-during-write on both ports.
    step(0, 1, 0, 0, 8, 32'hAAAA_0000, 32'h0000_3010);
    step(0, 1, 8, 8, 8, 32'h5555_FFFF, 32'h0000_3014);
    step(0, 0, 8, 8, 0, 0, 32'h0000_3018);

    // Reset wins over a simultaneous write.
    step(0, 1, 0, 0, 31, 32'hDEAD_BEEF, 32'h0000_301C);
    step(1, 1, 31, 5, 31, 32'h0000_3004, 32'h0000_3020);
    step(0, 0, 31, 5, 0, 0, 32'h0000_3024);

    // Counter saturation: 20 writes with a 4-bit counter.
    for (int i = 1; i <= 20; i++) step(0, 1, 5'(i - 1), 5'(i), 5'(i), $urandom, 32'h0000_4000 + 32'(4 * i));
    step(0, 0, 20, 1, 0, 0, 32'h0000_4100);

    // Random traffic with occasional reset.
    for (int k = 0; k < 300; k++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7),
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           $urandom, 32'h0000_5000 + 32'(4 * k));
    end
    reset = 1'b0; WE = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: pending=%0d want 0", exp_q.size());
    end
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
